// File: rtl/decomp_pkg.sv
// Shared types and sizing helpers for the codebook decompressor.
package decomp_pkg;

   // Top-level sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      DECODE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Tag width for a codebook of the given depth
   function automatic int unsigned tag_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/codebook_ram.sv
// Codebook storage: synchronous write, asynchronous read, contents not reset.
module codebook_ram #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned DATA_W = 24,
   parameter int unsigned AW     = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port, one codeword per enabled cycle
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/codebook_decompressor.sv
// Codebook decompressor: loads a codebook from RAM1, then maps RAM2 tags to
// RAM3 pixels at one pixel per cycle.
// Optional build macro: DECOMP_TAG_CHECK_EN enables out-of-range tag detection
// (such tags write 0 and raise a sticky tag_err).
module codebook_decompressor
   import decomp_pkg::*;
#(
   parameter  int unsigned DATA_W   = 24,
   parameter  int unsigned ADDR_W   = 20,
   parameter  int unsigned CB_DEPTH = 64,
   parameter  int unsigned TAG_Q_W  = 24,
   localparam int unsigned TAG_W    = tag_w(CB_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [TAG_W:0]    cb_size,
   input  logic [ADDR_W-1:0] num_pix,
   output logic              busy,
   output logic              done,
   output logic              tag_err,
   output logic [ADDR_W-1:0] RAM1_A,
   output logic              RAM1_OE,
   input  logic [DATA_W-1:0] RAM1_Q,
   output logic [ADDR_W-1:0] RAM2_A,
   output logic              RAM2_OE,
   input  logic [TAG_Q_W-1:0] RAM2_Q,
   output logic [ADDR_W-1:0] RAM3_A,
   output logic [DATA_W-1:0] RAM3_D,
   output logic              RAM3_WE
);

   localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(CB_DEPTH);

   state_t            state_q, state_d;
   logic [TAG_W:0]    eff_cb_q, eff_cb_d;
   logic [ADDR_W-1:0] num_pix_q, num_pix_d;
   logic [ADDR_W-1:0] ram1_a_q, ram1_a_d;
   logic              ram1_oe_q, ram1_oe_d;
   logic [ADDR_W-1:0] ram2_a_q, ram2_a_d;
   logic              ram2_oe_q, ram2_oe_d;
   logic [ADDR_W-1:0] ram3_a_q, ram3_a_d;
   logic              ram3_we_q, ram3_we_d;
   logic              cb_we_q, cb_we_d;
   logic [TAG_W-1:0]  cb_waddr_q, cb_waddr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [TAG_W:0]    eff_cb_c;
   logic [TAG_W-1:0]  tag_c;
   logic [DATA_W-1:0] cb_rdata_c;
   logic [DATA_W-1:0] pix_data_c;
   logic              unused_tag_hi;

   // Zero or oversized requests fall back to the full codebook
   assign eff_cb_c = ((cb_size == '0) || (cb_size > DEPTH_CNT)) ? DEPTH_CNT : cb_size;

   assign tag_c         = RAM2_Q[TAG_W-1:0];
   assign unused_tag_hi = ^RAM2_Q;

   codebook_ram #(
      .DEPTH  (CB_DEPTH),
      .DATA_W (DATA_W),
      .AW     (TAG_W)
   ) u_cb (
      .clk   (clk),
      .we    (cb_we_q),
      .waddr (cb_waddr_q),
      .wdata (RAM1_Q),
      .raddr (tag_c),
      .rdata (cb_rdata_c)
   );

   // Sequencer: start handshake, address generation and phase transitions
   always_comb begin
      state_d   = state_q;
      eff_cb_d  = eff_cb_q;
      num_pix_d = num_pix_q;
      ram1_a_d  = ram1_a_q;
      ram1_oe_d = 1'b0;
      ram2_a_d  = ram2_a_q;
      ram2_oe_d = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = LOAD;
               eff_cb_d  = eff_cb_c;
               num_pix_d = num_pix;
               ram1_a_d  = '0;
               ram1_oe_d = 1'b1;
            end
         end
         LOAD: begin
            if (ram1_oe_q) begin
               if (ram1_a_q == ADDR_W'(eff_cb_q) - ADDR_W'(1)) begin
                  ram1_a_d = '0;
               end else begin
                  ram1_a_d  = ram1_a_q + ADDR_W'(1);
                  ram1_oe_d = 1'b1;
               end
            end else begin
               // Drain cycle: last codeword lands this cycle
               state_d   = DECODE;
               ram2_a_d  = '0;
               ram2_oe_d = (num_pix_q != '0);
            end
         end
         DECODE: begin
            if (ram2_oe_q) begin
               if (ram2_a_q == num_pix_q - ADDR_W'(1)) begin
                  ram2_a_d = '0;
               end else begin
                  ram2_a_d  = ram2_a_q + ADDR_W'(1);
                  ram2_oe_d = 1'b1;
               end
            end else begin
               // Final write (if any) is on RAM3 this cycle
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == LOAD) || (state_d == DECODE);
      done_d = (state_d == DONE);
   end

   // One-cycle pipeline aligning addresses with RAM read data
   always_comb begin
      cb_we_d    = ram1_oe_q;
      cb_waddr_d = ram1_a_q[TAG_W-1:0];
      ram3_we_d  = ram2_oe_q;
      ram3_a_d   = ram2_oe_q ? ram2_a_q : '0;
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         eff_cb_q   <= '0;
         num_pix_q  <= '0;
         ram1_a_q   <= '0;
         ram1_oe_q  <= 1'b0;
         ram2_a_q   <= '0;
         ram2_oe_q  <= 1'b0;
         ram3_a_q   <= '0;
         ram3_we_q  <= 1'b0;
         cb_we_q    <= 1'b0;
         cb_waddr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         eff_cb_q   <= eff_cb_d;
         num_pix_q  <= num_pix_d;
         ram1_a_q   <= ram1_a_d;
         ram1_oe_q  <= ram1_oe_d;
         ram2_a_q   <= ram2_a_d;
         ram2_oe_q  <= ram2_oe_d;
         ram3_a_q   <= ram3_a_d;
         ram3_we_q  <= ram3_we_d;
         cb_we_q    <= cb_we_d;
         cb_waddr_q <= cb_waddr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

`ifdef DECOMP_TAG_CHECK_EN
   logic tag_bad_c;
   logic tag_err_q, tag_err_d;

   assign tag_bad_c = ram3_we_q && ({1'b0, tag_c} >= eff_cb_q);

   // Sticky error, cleared only by an accepted start
   always_comb begin
      tag_err_d = tag_err_q | tag_bad_c;
      if (start && ((state_q == IDLE) || (state_q == DONE))) begin
         tag_err_d = 1'b0;
      end
   end

   // Error flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_err_q <= 1'b0;
      end else begin
         tag_err_q <= tag_err_d;
      end
   end

   assign pix_data_c = tag_bad_c ? '0 : cb_rdata_c;
   assign tag_err    = tag_err_q;
`else
   assign pix_data_c = cb_rdata_c;
   assign tag_err    = 1'b0;
`endif

   // Pixel data is an unregistered codebook lookup, forced to 0 when not writing
   assign RAM3_D  = ram3_we_q ? pix_data_c : '0;

   assign busy    = busy_q;
   assign done    = done_q;
   assign RAM1_A  = ram1_a_q;
   assign RAM1_OE = ram1_oe_q;
   assign RAM2_A  = ram2_a_q;
   assign RAM2_OE = ram2_oe_q;
   assign RAM3_A  = ram3_a_q;
   assign RAM3_WE = ram3_we_q;

endmodule

// File: tb/tb_codebook_decompressor.sv
// Directed testbench for codebook_decompressor with RAM1/RAM2 read models.
module tb_codebook_decompressor;

`ifdef DECOMP_TAG_CHECK_EN
   localparam bit TAGCHK = 1'b1;
`else
   localparam bit TAGCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [6:0]  cb_size;
   logic [19:0] num_pix;
   logic        busy, done, tag_err;
   logic [19:0] RAM1_A, RAM2_A, RAM3_A;
   logic        RAM1_OE, RAM2_OE, RAM3_WE;
   logic [23:0] RAM1_Q, RAM2_Q, RAM3_D;

   logic [23:0] ram1 [0:127];
   logic [23:0] ram2 [0:4095];
   logic [23:0] ram3 [0:4095];

   int vectors    = 0;
   int miscompares = 0;
   int wr_cnt, oe1_cnt, viol;
   logic [19:0] max_a1;

   codebook_decompressor dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .cb_size (cb_size),
      .num_pix (num_pix),
      .busy    (busy),
      .done    (done),
      .tag_err (tag_err),
      .RAM1_A  (RAM1_A),
      .RAM1_OE (RAM1_OE),
      .RAM1_Q  (RAM1_Q),
      .RAM2_A  (RAM2_A),
      .RAM2_OE (RAM2_OE),
      .RAM2_Q  (RAM2_Q),
      .RAM3_A  (RAM3_A),
      .RAM3_D  (RAM3_D),
      .RAM3_WE (RAM3_WE)
   );

   always #5 clk = ~clk;

   // Synchronous-read source RAMs
   always @(posedge clk) begin
      if (RAM1_OE) RAM1_Q <= ram1[RAM1_A[6:0]];
      if (RAM2_OE) RAM2_Q <= ram2[RAM2_A[11:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Per-cycle observation of one operation; captures RAM3 writes
   task automatic observe();
      if (RAM1_OE) begin
         oe1_cnt++;
         if (RAM1_A > max_a1) max_a1 = RAM1_A;
      end
      if (RAM3_WE) begin
         wr_cnt++;
         if (!busy || RAM3_A > 20'd4095) viol++;
         else ram3[RAM3_A[11:0]] = RAM3_D;
      end
      if (RAM1_OE && RAM2_OE) viol++;
   endtask

   // One start-to-done operation; optional stray start pulse at cycle mid
   task automatic run(input logic [6:0] cb, input logic [19:0] np, input int mid, output int cyc);
      for (int i = 0; i < 4096; i++) ram3[i] = 24'hFFFFFF;
      wr_cnt = 0; oe1_cnt = 0; max_a1 = '0;
      @(posedge clk); #1;
      start = 1'b1; cb_size = cb; num_pix = np;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            check("start_busy", 32'(busy), 32'd1);
            check("start_tag_err_clr", 32'(tag_err), 32'd0);
         end
         if (cyc == mid) begin
            start = 1'b1; cb_size = 7'd0; num_pix = 20'd100;
         end
         if (cyc == mid + 1) start = 1'b0;
         observe();
      end while (!done && cyc < 20000);
   endtask

   int cyc;
   int errs;
   logic [23:0] expd;

   initial begin
      rst = 1'b1; start = 1'b0; cb_size = '0; num_pix = '0;
      viol = 0;
      #1;
      check("reset_ctrl", 32'({busy, done, tag_err, RAM1_OE, RAM2_OE, RAM3_WE}), 32'd0);
      check("reset_bus", 32'({|RAM1_A, |RAM2_A, |RAM3_A, |RAM3_D}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic: full codebook, 4096 pixels
      for (int k = 0; k < 128; k++) ram1[k] = 24'(k * 3);
      for (int i = 0; i < 4096; i++) ram2[i] = 24'hA5A5C0 | 24'(i % 64);
      run(7'd64, 20'd4096, 0, cyc);
      check("basic_cycles", 32'(cyc), 32'd4163);
      check("basic_writes", 32'(wr_cnt), 32'd4096);
      check("basic_loads", 32'(oe1_cnt), 32'd64);
      errs = 0;
      for (int i = 0; i < 4096; i++) if (ram3[i] !== 24'((i % 64) * 3)) errs++;
      check("basic_data", 32'(errs), 32'd0);
      check("basic_last_pix", 32'(ram3[4095]), 32'd189);

      // Small: 4 codewords, 8 pixels; then identical restart from DONE
      for (int k = 0; k < 128; k++) ram1[k] = 24'(k * 3 + 100);
      ram2[0] = 24'hA5A5C3; ram2[1] = 24'hA5A5C0; ram2[2] = 24'hA5A5C1; ram2[3] = 24'hA5A5C2;
      ram2[4] = 24'hA5A5C3; ram2[5] = 24'hA5A5C3; ram2[6] = 24'hA5A5C0; ram2[7] = 24'hA5A5C1;
      for (int r = 0; r < 3; r++) begin
         // third pass carries a stray start pulse during DECODE
         run(7'd4, 20'd8, (r == 2) ? 8 : 0, cyc);
         check("small_cycles", 32'(cyc), 32'd15);
         check("small_writes", 32'(wr_cnt), 32'd8);
         check("small_max_ram1_a", 32'(max_a1), 32'd3);
         errs = 0;
         for (int i = 0; i < 8; i++) if (ram3[i] !== 24'(ram2[i][5:0]) * 24'd3 + 24'd100) errs++;
         check("small_data", 32'(errs), 32'd0);
      end

      // Clamp and empty: cb_size 0 and oversized, no pixels
      for (int k = 0; k < 128; k++) ram1[k] = 24'(k * 5 + 1);
      run(7'd0, 20'd0, 0, cyc);
      check("clamp0_cycles", 32'(cyc), 32'd67);
      check("clamp0_loads", 32'(oe1_cnt), 32'd64);
      check("clamp0_max_ram1_a", 32'(max_a1), 32'd63);
      check("empty_writes", 32'(wr_cnt), 32'd0);
      check("empty_done", 32'(done), 32'd1);
      run(7'd100, 20'd0, 0, cyc);
      check("clamp100_cycles", 32'(cyc), 32'd67);
      check("clamp100_loads", 32'(oe1_cnt), 32'd64);

      // cb_size 1: tags above 0 are out of range
      ram1[0] = 24'h123456;
      for (int i = 0; i < 64; i++) ram2[i] = 24'hA5A5C0 | 24'(i);
      run(7'd1, 20'd64, 0, cyc);
      check("cb1_cycles", 32'(cyc), 32'd68);
      check("cb1_loads", 32'(oe1_cnt), 32'd1);
      errs = 0;
      for (int i = 0; i < 64; i++) begin
         expd = (i == 0) ? 24'h123456 : (TAGCHK ? 24'd0 : 24'(i * 5 + 1));
         if (ram3[i] !== expd) errs++;
      end
      check("cb1_data", 32'(errs), 32'd0);
      check("cb1_tag_err", 32'(tag_err), 32'(TAGCHK));

      // Out-of-range tag 9 at pixel 5 with 4 codewords
      for (int k = 0; k < 128; k++) ram1[k] = 24'(k * 3 + 100);
      ram2[0] = 24'hA5A5C0; ram2[1] = 24'hA5A5C1; ram2[2] = 24'hA5A5C2; ram2[3] = 24'hA5A5C3;
      ram2[4] = 24'hA5A5C0; ram2[5] = 24'hA5A5C9; ram2[6] = 24'hA5A5C1; ram2[7] = 24'hA5A5C2;
      run(7'd4, 20'd8, 0, cyc);
      check("oor_cycles", 32'(cyc), 32'd15);
      check("oor_pix5", 32'(ram3[5]), TAGCHK ? 32'd0 : 32'd46);
      errs = 0;
      for (int i = 0; i < 8; i++) if (i != 5 && ram3[i] !== 24'(ram2[i][5:0]) * 24'd3 + 24'd100) errs++;
      check("oor_other_pix", 32'(errs), 32'd0);
      repeat (3) @(posedge clk);
      #1 check("oor_tag_err_sticky", 32'(tag_err), 32'(TAGCHK));

      // Reset mid-DECODE aborts immediately
      for (int i = 0; i < 100; i++) ram2[i] = 24'hA5A5C0 | 24'(i % 4);
      @(posedge clk); #1;
      start = 1'b1; cb_size = 7'd4; num_pix = 20'd100;
      @(posedge clk); #1 start = 1'b0;
      repeat (18) @(posedge clk);
      #1 check("mid_decode_busy", 32'({busy, RAM2_OE}), 32'd3);
      rst = 1'b1;
      #1;
      check("abort_ctrl", 32'({busy, done, tag_err, RAM1_OE, RAM2_OE, RAM3_WE}), 32'd0);
      check("abort_bus", 32'({|RAM1_A, |RAM2_A, |RAM3_A, |RAM3_D}), 32'd0);
      errs = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (RAM3_WE || busy) errs++;
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (RAM3_WE || busy || done) errs++;
      check("abort_quiet", 32'(errs), 32'd0);

      // Recovery after reset
      run(7'd4, 20'd8, 0, cyc);
      check("recover_cycles", 32'(cyc), 32'd15);
      errs = 0;
      for (int i = 0; i < 8; i++) if (ram3[i] !== 24'((i % 4) * 3 + 100)) errs++;
      check("recover_data", 32'(errs), 32'd0);

      check("protocol_violations", 32'(viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
